// File: rtl/prbs_pkg.sv
// Shared PRBS7 constants and checker state type for the pattern generator/checker pair.
package prbs_pkg;

  localparam int PRBS7_ORDER = 7;
  localparam int PRBS7_TAP_A = 6;
  localparam int PRBS7_TAP_B = 5;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

endpackage

// File: rtl/prbs7_checker_if.sv
// Stream, control and status bundle for prbs7_checker.
// Optional macro PRBS7_CHK_ERR_INJECT_EN adds the inject_err request line.
interface prbs7_checker_if #(
  parameter int ERR_W = 16,
  parameter int CNT_W = 32
);

  logic             clear;
  logic             rx_bit;
  logic             rx_valid;
`ifdef PRBS7_CHK_ERR_INJECT_EN
  logic             inject_err;
`endif
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;
  logic             lock_lost;

`ifdef PRBS7_CHK_ERR_INJECT_EN
  modport master (output clear, rx_bit, rx_valid, inject_err,
                  input  locked, err_pulse, err_count, bit_count, lock_lost);
  modport slave  (input  clear, rx_bit, rx_valid, inject_err,
                  output locked, err_pulse, err_count, bit_count, lock_lost);
`else
  modport master (output clear, rx_bit, rx_valid,
                  input  locked, err_pulse, err_count, bit_count, lock_lost);
  modport slave  (input  clear, rx_bit, rx_valid,
                  output locked, err_pulse, err_count, bit_count, lock_lost);
`endif

endinterface

// File: rtl/prbs7_predictor.sv
// Seven-bit history register and next-bit predictor for the PRBS7 checker.
module prbs7_predictor
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic shift_en_i,
  input  logic flush_i,
  input  logic sel_pred_i,
  input  logic rx_bit_i,
  output logic predicted_o,
  output logic hist_nz_o
);

  logic [PRBS7_ORDER-1:0] hist_q, hist_d;
  logic                   shift_in;

  assign predicted_o = hist_q[PRBS7_TAP_A] ^ hist_q[PRBS7_TAP_B];
  assign hist_nz_o   = |hist_q;
  // Once locked, the local prediction is fed back so a corrupted bit never enters the history.
  assign shift_in    = sel_pred_i ? predicted_o : rx_bit_i;

  always_comb begin
    hist_d = hist_q;
    if (flush_i) begin
      hist_d = '0;
    end else if (shift_en_i) begin
      hist_d = {hist_q[PRBS7_ORDER-2:0], shift_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 bit-error checker with saturating counters and windowed loss-of-lock.
// Optional macro PRBS7_CHK_ERR_INJECT_EN enables single-error injection while locked.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 16,
  parameter int ERR_W       = 16,
  parameter int CNT_W       = 32,
  parameter int WIN         = 64,
  parameter int LOSS_THRESH = 8
) (
  input logic            clk,
  input logic            reset,
  prbs7_checker_if.slave bus
);

  localparam int FILL_W  = $clog2(PRBS7_ORDER + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN + 1);
  localparam int THR_W   = $clog2(LOSS_THRESH + 1);

  chk_state_e         state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [THR_W-1:0]   win_err_q, win_err_d, win_err_nxt;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;
  logic               err_pulse_q, err_pulse_d;
  logic               lock_lost_q, lock_lost_d;

  logic shift_en, flush, sel_pred;
  logic predicted, hist_nz;
  logic cmp_bit, mismatch;

  prbs7_predictor u_predictor (
    .clk         (clk),
    .reset       (reset),
    .shift_en_i  (shift_en),
    .flush_i     (flush),
    .sel_pred_i  (sel_pred),
    .rx_bit_i    (bus.rx_bit),
    .predicted_o (predicted),
    .hist_nz_o   (hist_nz)
  );

`ifdef PRBS7_CHK_ERR_INJECT_EN
  assign cmp_bit = bus.rx_bit ^ bus.inject_err;
`else
  assign cmp_bit = bus.rx_bit;
`endif
  assign mismatch = cmp_bit ^ predicted;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;
    shift_en    = 1'b0;
    flush       = 1'b0;
    sel_pred    = 1'b0;
    win_err_nxt = win_err_q + THR_W'(mismatch);

    if (bus.rx_valid) begin
      unique case (state_q)
        HUNT: begin
          shift_en = 1'b1;
          if (fill_q != FILL_W'(PRBS7_ORDER)) begin
            fill_d = fill_q + FILL_W'(1);
          end else if ((bus.rx_bit == predicted) && hist_nz) begin
            if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d   = LOCKED;
              match_d   = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end

        LOCKED: begin
          shift_en = 1'b1;
          sel_pred = 1'b1;
          if (bit_count_q != '1) begin
            bit_count_d = bit_count_q + CNT_W'(1);
          end
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
          end
          // Too many errors in one window: drop back and resynchronise from scratch.
          if (win_err_nxt == THR_W'(LOSS_THRESH)) begin
            state_d     = HUNT;
            fill_d      = '0;
            match_d     = '0;
            flush       = 1'b1;
            lock_lost_d = 1'b1;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else if (win_cnt_q == WIN_W'(WIN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_err_nxt;
          end
        end

        default: ;
      endcase
    end

    if (bus.clear) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.bit_count = bit_count_q;
  assign bus.lock_lost = lock_lost_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Self-checking bench for prbs7_checker: queue-based reference model plus directed literal checks.
module tb_prbs7_checker;

  localparam int LOCK_CNT    = 16;
  localparam int WIN         = 64;
  localparam int LOSS_THRESH = 8;
  localparam longint ERR_MAX   = 65535;
  localparam longint SMALL_MAX = 15;
  localparam longint BITS_MAX  = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxBit = 1'b0;
  logic rxValid = 1'b0;
  logic clear = 1'b0;
  logic [6:0] gen = 7'd1;

  int assertCount = 0;
  int failCount = 0;
  bit checkEnable = 1'b0;
  int errPulseSeen = 0;
  int lostSeen = 0;

  prbs7_checker_if #(.ERR_W(16), .CNT_W(32)) busMain ();
  prbs7_checker_if #(.ERR_W(4),  .CNT_W(32)) busSmall ();

  assign busMain.rx_bit    = rxBit;
  assign busMain.rx_valid  = rxValid;
  assign busMain.clear     = clear;
  assign busSmall.rx_bit   = rxBit;
  assign busSmall.rx_valid = rxValid;
  assign busSmall.clear    = clear;
`ifdef PRBS7_CHK_ERR_INJECT_EN
  assign busMain.inject_err  = 1'b0;
  assign busSmall.inject_err = 1'b0;
`endif

  prbs7_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(16), .CNT_W(32), .WIN(WIN), .LOSS_THRESH(LOSS_THRESH)) dut (
    .clk(clk), .reset(reset), .bus(busMain));

  prbs7_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(4), .CNT_W(32), .WIN(WIN), .LOSS_THRESH(LOSS_THRESH)) dutSmall (
    .clk(clk), .reset(reset), .bus(busSmall));

  always #5 clk = ~clk;

  // Reference model: last seven bits kept oldest-first in a queue, counts kept unsaturated.
  bit     histQ[$];
  bit     mLocked = 1'b0;
  int     matchRun = 0;
  int     winPos = 0;
  int     winErr = 0;
  longint mErr = 0;
  longint mBits = 0;
  bit     mErrPulse = 1'b0;
  bit     mLockLost = 1'b0;
  bit     pred, nonZero, bad;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      histQ.delete();
      mLocked = 1'b0; matchRun = 0; winPos = 0; winErr = 0;
      mErr = 0; mBits = 0; mErrPulse = 1'b0; mLockLost = 1'b0;
    end else begin
      mErrPulse = 1'b0;
      mLockLost = 1'b0;
      if (rxValid) begin
        if (!mLocked) begin
          if (histQ.size() < 7) begin
            histQ.push_back(rxBit);
          end else begin
            pred = histQ[0] ^ histQ[1];
            nonZero = 1'b0;
            foreach (histQ[i]) if (histQ[i]) nonZero = 1'b1;
            if (rxBit == pred && nonZero) matchRun++;
            else matchRun = 0;
            void'(histQ.pop_front());
            histQ.push_back(rxBit);
            if (matchRun == LOCK_CNT) begin
              mLocked = 1'b1; matchRun = 0; winPos = 0; winErr = 0;
            end
          end
        end else begin
          pred = histQ[0] ^ histQ[1];
          bad = (rxBit != pred);
          void'(histQ.pop_front());
          histQ.push_back(pred);
          mBits++;
          if (bad) begin mErr++; mErrPulse = 1'b1; winErr++; end
          winPos++;
          if (winErr >= LOSS_THRESH) begin
            mLocked = 1'b0; histQ.delete(); matchRun = 0; mLockLost = 1'b1;
            winPos = 0; winErr = 0;
          end else if (winPos == WIN) begin
            winPos = 0; winErr = 0;
          end
        end
        if (clear) begin mErr = 0; mBits = 0; end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic longint satTo(input longint v, input longint maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("locked", busMain.locked, mLocked);
      checkOutput("err_pulse", busMain.err_pulse, mErrPulse);
      checkOutput("lock_lost", busMain.lock_lost, mLockLost);
      checkOutput("err_count", busMain.err_count, satTo(mErr, ERR_MAX));
      checkOutput("bit_count", busMain.bit_count, satTo(mBits, BITS_MAX));
      checkOutput("err_count_w4", busSmall.err_count, satTo(mErr, SMALL_MAX));
      if (busMain.err_pulse) errPulseSeen++;
      if (busMain.lock_lost) lostSeen++;
    end
  end

  task automatic driveBeat(input logic b, input logic v, input logic c);
    rxBit = b; rxValid = v; clear = c;
    @(posedge clk); #1;
    rxValid = 1'b0; clear = 1'b0;
  endtask

  // One beat of generator output; the generator only advances on valid beats.
  task automatic applyStimulus(input logic v, input logic inv, input logic c);
    logic outBit;
    outBit = gen[6];
    if (v) gen = {gen[5:0], gen[6] ^ gen[5]};
    driveBeat(outBit ^ inv, v, c);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    gen = 7'd1;
  endtask

  task automatic lockUp(input string name);
    for (int i = 1; i <= 23; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (i == 22) checkOutput({name, "_not_yet"}, busMain.locked, 1'b0);
    end
    checkOutput({name, "_locked"}, busMain.locked, 1'b1);
  endtask

  initial begin
    int burstLeft;
    logic v, inv, c;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkEnable = 1'b1;
    checkOutput("reset_locked", busMain.locked, 1'b0);
    checkOutput("reset_err_count", busMain.err_count, 0);

    // Continuous clean stream
    lockUp("clean");
    repeat (1000) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("clean_err_count", busMain.err_count, 0);
    checkOutput("clean_bit_count", busMain.bit_count, 1000);

    // Single flipped bit
    errPulseSeen = 0;
    repeat (199) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (300) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("single_pulses", errPulseSeen, 1);
    checkOutput("single_err_count", busMain.err_count, 1);
    checkOutput("single_still_locked", busMain.locked, 1'b1);

    // Stuck-at-zero input never locks
    doReset();
    repeat (200) driveBeat(1'b0, 1'b1, 1'b0);
    checkOutput("zero_locked", busMain.locked, 1'b0);
    checkOutput("zero_err_count", busMain.err_count, 0);

    // Error burst forces loss of lock, then relock
    doReset();
    lockUp("burst");
    lostSeen = 0;
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("burst_lost_locked", busMain.locked, 1'b0);
    checkOutput("burst_lost_pulse", busMain.lock_lost, 1'b1);
    lockUp("relock");
    checkOutput("burst_lost_count", lostSeen, 1);
    checkOutput("burst_err_count", busMain.err_count, 8);

    // Gapped valid, then saturation of the narrow counter
    doReset();
    for (int i = 0; i < 46; i++) begin
      applyStimulus((i % 2) == 0, 1'b0, 1'b0);
      if (i == 42) checkOutput("gap_not_yet", busMain.locked, 1'b0);
      if (i == 44) checkOutput("gap_locked", busMain.locked, 1'b1);
    end
    checkOutput("gap_idle_pulse", busMain.err_pulse, 1'b0);
    checkOutput("gap_err_count", busMain.err_count, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) applyStimulus(1'b1, (i % 10) == 5, 1'b0);
    checkOutput("sat_err_w4", busSmall.err_count, 15);
    checkOutput("sat_err_w16", busMain.err_count, 20);
    checkOutput("sat_locked", busMain.locked, 1'b1);

    // Reset while locked, then clear coincident with an error
    doReset();
    lockUp("rst");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("rst_pre_err", busMain.err_count, 5);
    reset = 1'b1;
    #1;
    checkOutput("rst_locked", busMain.locked, 1'b0);
    checkOutput("rst_err_count", busMain.err_count, 0);
    checkOutput("rst_bit_count", busMain.bit_count, 0);
    checkOutput("rst_err_pulse", busMain.err_pulse, 1'b0);
    checkOutput("rst_lock_lost", busMain.lock_lost, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    gen = 7'd1;
    lockUp("clr");
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clr_err_count", busMain.err_count, 0);
    checkOutput("clr_err_pulse", busMain.err_pulse, 1'b1);

    // Randomised traffic with sparse errors, occasional bursts and clears
    burstLeft = 0;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 7);
      if (v && burstLeft == 0 && $urandom_range(0, 499) == 0) burstLeft = 8;
      inv = v && ((burstLeft > 0) || ($urandom_range(0, 49) == 0));
      if (v && burstLeft > 0) burstLeft--;
      c = v && ($urandom_range(0, 31) == 0);
      applyStimulus(v, inv, c);
    end

    checkEnable = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
